// File: rtl/pe_vector_sequencer_pkg.sv
// pe_vector_sequencer_pkg: shared widths, PE mode codes, sequencer state encodings
// and the Q3.12 saturation helper.
`default_nettype none

package pe_vector_sequencer_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 12;
  localparam int EXT_WIDTH  = 40;

  localparam logic [1:0] MODE_MAC = 2'd0;
  localparam logic [1:0] MODE_MUL = 2'd1;
  localparam logic [1:0] MODE_ADD = 2'd2;

  localparam logic signed [EXT_WIDTH-1:0] SAT_MAX = EXT_WIDTH'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1);
  localparam logic signed [EXT_WIDTH-1:0] SAT_MIN = EXT_WIDTH'(-(64'sd1 <<< (DATA_WIDTH-1)));

  typedef enum logic [3:0] {
    SEQ_IDLE    = 4'd0,
    SEQ_CLEAR   = 4'd1,
    SEQ_RUN     = 4'd2,
    SEQ_DRAIN   = 4'd3,
    SEQ_ISSUE   = 4'd4,
    SEQ_EXEC    = 4'd5,
    SEQ_CAPTURE = 4'd6,
    SEQ_OUT     = 4'd7,
    SEQ_FINISH  = 4'd8
  } seq_state_t;

  function automatic logic [DATA_WIDTH-1:0] sat_q(input logic signed [EXT_WIDTH-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  function automatic logic mode_legal(input logic [1:0] m);
    return (m == MODE_MAC) || (m == MODE_MUL) || (m == MODE_ADD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/Unified_PE.sv
// Unified_PE: Q3.12 processing element with a saturating MAC accumulator and
// one-shot MUL/ADD; the result is registered one cycle after the operands.
`default_nettype none

module Unified_PE
  import pe_vector_sequencer_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_acc,
  input  logic [1:0]                   op_mode,
  input  logic signed [DATA_WIDTH-1:0] in_A,
  input  logic signed [DATA_WIDTH-1:0] in_B,
  output logic signed [DATA_WIDTH-1:0] out_val
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [EXT_WIDTH-1:0]    w_prod_q;
  logic signed [EXT_WIDTH-1:0]    w_acc_sum;
  logic signed [EXT_WIDTH-1:0]    w_add_sum;
  logic signed [DATA_WIDTH-1:0]   r_acc;
  logic signed [DATA_WIDTH-1:0]   r_out;

  // Product is truncated toward minus infinity before accumulation.
  assign w_prod    = in_A * in_B;
  assign w_prod_q  = $signed({{(EXT_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod}) >>> FRAC_BITS;
  assign w_acc_sum = $signed({{(EXT_WIDTH-DATA_WIDTH){r_acc[DATA_WIDTH-1]}}, r_acc}) + w_prod_q;
  assign w_add_sum = $signed({{(EXT_WIDTH-DATA_WIDTH){in_A[DATA_WIDTH-1]}}, in_A})
                   + $signed({{(EXT_WIDTH-DATA_WIDTH){in_B[DATA_WIDTH-1]}}, in_B});
  assign out_val   = r_out;

  always_ff @(posedge clk) begin
    if (reset || clear_acc) begin
      r_acc <= '0;
      r_out <= '0;
    end else begin
      case (op_mode)
        MODE_MAC: begin
          r_acc <= sat_q(w_acc_sum);
          r_out <= sat_q(w_acc_sum);
        end
        MODE_MUL: r_out <= sat_q(w_prod_q);
        MODE_ADD: r_out <= sat_q(w_add_sum);
        default:  r_out <= r_out;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_vector_sequencer.sv
// pe_vector_sequencer: command-driven controller that streams operand vectors
// through one Unified_PE and returns a dot product (MAC) or per-element results.
`default_nettype none

module pe_vector_sequencer
  import pe_vector_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ADDR_WIDTH-1:0] cmd_base_a,
  input  logic [ADDR_WIDTH-1:0] cmd_base_b,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done
);

  seq_state_t            r_state;
  logic [1:0]            r_mode;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_k;
  logic [ADDR_WIDTH-1:0] r_addr_a;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic                  r_rd_en;
  logic                  r_clear;
  logic                  r_present;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_valid;
  logic                  r_res_last;

  logic                  w_last_k;
  logic                  w_next_more;
  logic [1:0]            w_op_mode;
  logic [DATA_WIDTH-1:0] w_in_a;
  logic [DATA_WIDTH-1:0] w_in_b;
  logic [DATA_WIDTH-1:0] w_pe_out;

  assign w_last_k    = (r_k == (r_len - LEN_WIDTH'(1)));
  assign w_next_more = (({1'b0, r_k} + (LEN_WIDTH+1)'(2)) < {1'b0, r_len});

  // Operands reach the PE only in the cycle after a read; otherwise it holds.
  assign w_op_mode = r_present ? r_mode    : MODE_MAC;
  assign w_in_a    = r_present ? rd_data_a : '0;
  assign w_in_b    = r_present ? rd_data_b : '0;

  Unified_PE u_pe (
    .clk       (clk),
    .reset     (reset),
    .clear_acc (r_clear),
    .op_mode   (w_op_mode),
    .in_A      ($signed(w_in_a)),
    .in_B      ($signed(w_in_b)),
    .out_val   (w_pe_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEQ_IDLE;
      r_mode      <= MODE_MAC;
      r_len       <= '0;
      r_k         <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_rd_en     <= 1'b0;
      r_clear     <= 1'b0;
      r_present   <= 1'b0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
    end else begin
      r_present <= r_rd_en;
      case (r_state)
        SEQ_IDLE: begin
          if (cmd_valid) begin
            r_mode   <= cmd_mode;
            r_len    <= cmd_len;
            r_k      <= '0;
            r_addr_a <= cmd_base_a;
            r_addr_b <= cmd_base_b;
            if (!mode_legal(cmd_mode) || (cmd_len == '0)) begin
              r_state <= SEQ_FINISH;
            end else if (cmd_mode == MODE_MAC) begin
              r_state <= SEQ_CLEAR;
              r_clear <= 1'b1;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= SEQ_ISSUE;
              r_rd_en <= 1'b1;
            end
          end
        end
        SEQ_CLEAR: begin
          r_clear  <= 1'b0;
          r_state  <= SEQ_RUN;
          r_rd_en  <= (r_len > LEN_WIDTH'(1));
          r_addr_a <= r_addr_a + ADDR_WIDTH'(1);
          r_addr_b <= r_addr_b + ADDR_WIDTH'(1);
        end
        SEQ_RUN: begin
          if (w_last_k) begin
            r_state <= SEQ_DRAIN;
            r_rd_en <= 1'b0;
          end else begin
            r_k      <= r_k + LEN_WIDTH'(1);
            r_rd_en  <= w_next_more;
            r_addr_a <= r_addr_a + ADDR_WIDTH'(1);
            r_addr_b <= r_addr_b + ADDR_WIDTH'(1);
          end
        end
        SEQ_DRAIN: begin
          r_res_data  <= w_pe_out;
          r_res_valid <= 1'b1;
          r_res_last  <= 1'b1;
          r_state     <= SEQ_OUT;
        end
        SEQ_ISSUE: begin
          r_rd_en <= 1'b0;
          r_state <= SEQ_EXEC;
        end
        SEQ_EXEC: r_state <= SEQ_CAPTURE;
        SEQ_CAPTURE: begin
          r_res_data  <= w_pe_out;
          r_res_valid <= 1'b1;
          r_res_last  <= w_last_k;
          r_state     <= SEQ_OUT;
        end
        SEQ_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
            if (w_last_k) begin
              r_state <= SEQ_IDLE;
            end else begin
              r_k      <= r_k + LEN_WIDTH'(1);
              r_addr_a <= r_addr_a + ADDR_WIDTH'(1);
              r_addr_b <= r_addr_b + ADDR_WIDTH'(1);
              r_rd_en  <= 1'b1;
              r_state  <= SEQ_ISSUE;
            end
          end
        end
        SEQ_FINISH: r_state <= SEQ_IDLE;
        default:    r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == SEQ_IDLE);
  assign busy      = (r_state != SEQ_IDLE);
  assign done      = (r_state == SEQ_FINISH) || ((r_state == SEQ_OUT) && res_ready && r_res_last);
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_addr_a;
  assign rd_addr_b = r_addr_b;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_last  = r_res_last;

endmodule

`default_nettype wire

// File: tb/tb_pe_vector_sequencer.sv
// tb_pe_vector_sequencer: directed commands against a queue-based reference model
// of the operand reads and results, plus literal expectations from hand arithmetic.
`default_nettype none

module tb_pe_vector_sequencer;

  localparam int AW = 10;
  localparam int LW = 11;
  localparam logic [1:0] M_MAC = 2'd0;
  localparam logic [1:0] M_MUL = 2'd1;
  localparam logic [1:0] M_ADD = 2'd2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = 2'd0;
  logic [LW-1:0] cmd_len = '0;
  logic [AW-1:0] cmd_base_a = '0;
  logic [AW-1:0] cmd_base_b = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [15:0]   rd_data_a = '0;
  logic [15:0]   rd_data_b = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [15:0]   res_data;
  logic          res_last;
  logic          busy, done;

  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_addr_a[$], exp_addr_b[$], exp_data[$], exp_last[$];
  int seen_a[$];
  int got_q[$];

  pe_vector_sequencer #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr_a];
      rd_data_b <= mem_b[rd_addr_b];
    end
  end

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Q3.12 product, floor rounding.
  function automatic longint qmul(int a, int b);
    longint p;
    p = longint'(a) * longint'(b);
    return p >>> 12;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_vs_busy", cmd_ready, !busy);
      if (rd_en) begin
        seen_a.push_back(int'(rd_addr_a));
        if (exp_addr_a.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rd_en: got addr 0x%0h expected no read", rd_addr_a);
        end else begin
          chk("rd_addr_a", rd_addr_a, exp_addr_a.pop_front());
          chk("rd_addr_b", rd_addr_b, exp_addr_b.pop_front());
        end
      end
      if (res_valid) begin
        if (exp_data.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_res_valid: got data 0x%0h expected no result", res_data);
        end else begin
          chk("res_data", res_data, exp_data[0] & 16'hFFFF);
          chk("res_last", res_last, exp_last[0]);
          if (res_ready) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [1:0] mode, input int n, input int ba, input int bb);
    longint acc;
    int a, b;
    if (mode == 2'd3 || n == 0) return;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      exp_addr_a.push_back((ba + k) % 1024);
      exp_addr_b.push_back((bb + k) % 1024);
      a = int'($signed(mem_a[(ba + k) % 1024]));
      b = int'($signed(mem_b[(bb + k) % 1024]));
      if (mode == M_MAC) acc = sat16(acc + qmul(a, b));
      else if (mode == M_MUL) begin exp_data.push_back(sat16(qmul(a, b))); exp_last.push_back(k == n - 1); end
      else begin exp_data.push_back(sat16(longint'(a) + longint'(b))); exp_last.push_back(k == n - 1); end
    end
    if (mode == M_MAC) begin exp_data.push_back(int'(acc)); exp_last.push_back(1); end
  endtask

  task automatic issue(input logic [1:0] mode, input int n, input int ba, input int bb);
    int guard = 0;
    model_push(mode, n, ba, bb);
    while (!cmd_ready && guard < 200) begin cycle(); guard++; end
    if (!cmd_ready) begin checks++; failures++; $display("FAIL cmd_ready_timeout: got 0 expected 1"); end
    cmd_valid = 1'b1; cmd_mode = mode; cmd_len = LW'(n);
    cmd_base_a = AW'(ba); cmd_base_b = AW'(bb);
    cycle();
    cmd_valid = 1'b0; cmd_mode = 2'd3; cmd_len = '0; cmd_base_a = '1; cmd_base_b = '1;
  endtask

  task automatic collect(input int n_res, input int stall_k, input int stall_n, input int exp_lat);
    int w;
    for (int k = 0; k < n_res; k++) begin
      w = 0;
      while (!res_valid && w < 300) begin cycle(); w++; end
      if (!res_valid) begin
        checks++; failures++;
        $display("FAIL res_valid_timeout: got 0 expected 1 (result %0d)", k);
        return;
      end
      if (k == 0 && exp_lat > 0) chk("latency", w + 1, exp_lat);
      if (k == stall_k) repeat (stall_n) begin chk("no_done_in_stall", done, 0); cycle(); end
      res_ready = 1'b1;
      #1;
      got_q.push_back(int'(res_data));
      chk("done_on_handshake", done, (k == n_res - 1));
      cycle();
      res_ready = 1'b0;
      chk("busy_after_handshake", busy, (k != n_res - 1));
    end
    chk("done_single_pulse", done, 0);
  endtask

  task automatic expect_quick_done();
    chk("quick_done", done, 1);
    cycle();
    chk("quick_done_drop", done, 0);
    chk("quick_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    for (int i = 0; i < 4; i++)  begin mem_a[i] = 16'h1000; mem_b[16'h100 + i] = 16'h0800; end
    for (int i = 0; i < 16; i++) begin mem_a[16'h020 + i] = 16'h7000; mem_b[16'h120 + i] = 16'h7000; end
    mem_a[16'h040] = 16'h1000; mem_a[16'h041] = 16'h2000; mem_a[16'h042] = 16'hF000;
    for (int i = 0; i < 3; i++)  mem_b[16'h140 + i] = 16'h1800;
    mem_a[16'h3FF] = 16'h1000; mem_b[16'h160] = 16'h0200; mem_b[16'h161] = 16'h7000;
    for (int i = 0; i < 8; i++)  begin mem_a[16'h080 + i] = 16'h1000; mem_b[16'h180 + i] = 16'h1000; end

    cycle(); cycle();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_rd_en", rd_en, 0);
    reset = 1'b0;
    cycle();

    // MAC, N=4: 4 * (1.0*0.5) = 2.0
    got_q.delete();
    issue(M_MAC, 4, 0, 16'h100);
    collect(1, -1, 0, 7);
    chk("mac4_literal", (got_q.size() > 0) ? got_q[0] : -1, 16'h2000);

    // MAC, N=16, saturating
    got_q.delete();
    issue(M_MAC, 16, 16'h020, 16'h120);
    collect(1, -1, 0, 19);
    chk("mac16_sat_literal", (got_q.size() > 0) ? got_q[0] : -1, 16'h7FFF);

    // MUL, N=3, 5-cycle stall on element 1
    got_q.delete();
    issue(M_MUL, 3, 16'h040, 16'h140);
    collect(3, 1, 5, 4);
    chk("mul_e0_literal", (got_q.size() > 0) ? got_q[0] : -1, 16'h1800);
    chk("mul_e1_literal", (got_q.size() > 1) ? got_q[1] : -1, 16'h3000);
    chk("mul_e2_literal", (got_q.size() > 2) ? got_q[2] : -1, 16'hE800);

    // ADD, N=2, base_a wraps 0x3FF -> 0x000
    got_q.delete(); seen_a.delete();
    issue(M_ADD, 2, 16'h3FF, 16'h160);
    collect(2, -1, 0, 4);
    chk("add_addr0_literal", (seen_a.size() > 0) ? seen_a[0] : -1, 16'h3FF);
    chk("add_addr1_literal", (seen_a.size() > 1) ? seen_a[1] : -1, 16'h000);
    chk("add_e0_literal", (got_q.size() > 0) ? got_q[0] : -1, 16'h1200);
    chk("add_e1_sat_literal", (got_q.size() > 1) ? got_q[1] : -1, 16'h7FFF);

    // N=0 and illegal mode: no reads, no results, immediate done
    issue(M_MAC, 0, 0, 16'h100);
    expect_quick_done();
    issue(2'd3, 4, 0, 16'h100);
    expect_quick_done();
    repeat (3) cycle();

    // Reset during MAC RUN at k=2
    issue(M_MAC, 8, 16'h080, 16'h180);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_addr_a.delete(); exp_addr_b.delete(); exp_data.delete(); exp_last.delete();
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", res_data, 0);
    chk("midrst_res_last", res_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_addr", rd_addr_a, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    cycle();

    got_q.delete();
    issue(M_MAC, 4, 0, 16'h100);
    collect(1, -1, 0, 7);
    chk("mac_after_reset_literal", (got_q.size() > 0) ? got_q[0] : -1, 16'h2000);

    repeat (3) cycle();
    chk("done_count", done_cnt, 7);
    chk("model_drained", exp_data.size() + exp_addr_a.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
